// File: rtl/clock_time_counter_pkg.sv
// rtl/clock_time_counter_pkg.sv - BCD limits and digit helpers shared by the time counter
package clock_pkg;

   localparam logic [7:0] SEC_MAX = 8'h59;
   localparam logic [7:0] MIN_MAX = 8'h59;

   typedef struct packed {
      logic [7:0] value;
      logic       wrap;
   } bcd_step_t;

   // Digits are advanced in place so the counter never holds a binary value.
   function automatic bcd_step_t bcd_inc(input logic [7:0] val, input logic [7:0] max);
      bcd_step_t r;
      r.wrap = 1'b0;
      if (val == max) begin
         r.value = 8'h00;
         r.wrap  = 1'b1;
      end else if (val[3:0] == 4'd9) begin
         r.value = {val[7:4] + 4'd1, 4'd0};
      end else begin
         r.value = {val[7:4], val[3:0] + 4'd1};
      end
      return r;
   endfunction

   function automatic logic bcd_valid(input logic [7:0] val, input logic [7:0] max);
      return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max);
   endfunction

   function automatic logic [7:0] to_bcd(input int unsigned bin);
      return {4'(bin / 10), 4'(bin % 10)};
   endfunction

endpackage

// File: rtl/clock_time_counter_if.sv
// rtl/clock_time_counter_if.sv - tick input, time-set and time/carry outputs of the counter
interface clock_time_counter_if;
   logic       tick_in;
   logic       run;
   logic       load;
   logic [7:0] load_hour;
   logic [7:0] load_min;
   logic [7:0] load_sec;
   logic [7:0] hour_bcd;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       tick_pulse;
   logic       min_carry;
   logic       day_carry;
   logic       load_err;

   modport master (
      output tick_in, run, load, load_hour, load_min, load_sec,
      input  hour_bcd, min_bcd, sec_bcd, tick_pulse, min_carry, day_carry, load_err
   );

   modport slave (
      input  tick_in, run, load, load_hour, load_min, load_sec,
      output hour_bcd, min_bcd, sec_bcd, tick_pulse, min_carry, day_carry, load_err
   );
endinterface

// File: rtl/clock_time_counter_tick_edge_sync.sv
// rtl/clock_time_counter_tick_edge_sync.sv - tick_in synchroniser, rising-edge detect and pulse register
module tick_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_in,
   output logic tick_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;

   // Chain resets high so a tick already high at reset release is not an edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q     <= '1;
         edge_q     <= 1'b1;
         tick_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], tick_in};
         edge_q     <= sync_q[SYNC_STAGES-1];
         tick_pulse <= sync_q[SYNC_STAGES-1] & ~edge_q;
      end
   end

endmodule

// File: rtl/clock_time_counter.sv
// rtl/clock_time_counter.sv - BCD HH:MM:SS counter advanced by synchronised tick edges
module clock_time_counter
   import clock_pkg::*;
#(
   parameter int MAX_HOUR    = 23,
   parameter int SYNC_STAGES = 2
) (
   input logic                 clk,
   input logic                 rst,
   clock_time_counter_if.slave bus
);

   localparam logic [7:0] HOUR_MAX = to_bcd(MAX_HOUR);

   logic       tick_pulse;
   logic [7:0] hour_q, min_q, sec_q;
   logic       min_carry_q, day_carry_q, load_err_q;
   bcd_step_t  sec_step, min_step, hour_step;
   logic       load_ok;

   tick_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst        (rst),
      .tick_in    (bus.tick_in),
      .tick_pulse (tick_pulse)
   );

   always_comb begin
      sec_step  = bcd_inc(sec_q, SEC_MAX);
      min_step  = bcd_inc(min_q, MIN_MAX);
      hour_step = bcd_inc(hour_q, HOUR_MAX);
      load_ok   = bcd_valid(bus.load_sec, SEC_MAX) && bcd_valid(bus.load_min, MIN_MAX)
                  && bcd_valid(bus.load_hour, HOUR_MAX);
   end

   // Load outranks a tick in the same cycle; that tick is simply dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hour_q      <= 8'h00;
         min_q       <= 8'h00;
         sec_q       <= 8'h00;
         min_carry_q <= 1'b0;
         day_carry_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         min_carry_q <= 1'b0;
         day_carry_q <= 1'b0;
         load_err_q  <= 1'b0;
         if (bus.load) begin
            if (load_ok) begin
               hour_q <= bus.load_hour;
               min_q  <= bus.load_min;
               sec_q  <= bus.load_sec;
            end else begin
               load_err_q <= 1'b1;
            end
         end else if (tick_pulse && bus.run) begin
            sec_q <= sec_step.value;
            if (sec_step.wrap) begin
               min_q       <= min_step.value;
               min_carry_q <= 1'b1;
               if (min_step.wrap) begin
                  hour_q      <= hour_step.value;
                  day_carry_q <= hour_step.wrap;
               end
            end
         end
      end
   end

   assign bus.hour_bcd   = hour_q;
   assign bus.min_bcd    = min_q;
   assign bus.sec_bcd    = sec_q;
   assign bus.tick_pulse = tick_pulse;
   assign bus.min_carry  = min_carry_q;
   assign bus.day_carry  = day_carry_q;
   assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// tb/tb_clock_time_counter.sv - scoreboard bench for the BCD time counter
module tb_clock_time_counter;

   typedef struct packed {
      int         cyc;
      logic [7:0] h;
      logic [7:0] m;
      logic [7:0] s;
      logic       tp;
      logic       mc;
      logic       dc;
      logic       le;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;
   ev_t  exp_q[$];
   logic [7:0] cur_h = 8'h00, cur_m = 8'h00, cur_s = 8'h00;
   logic [23:0] prev_time = 24'h0;

   clock_time_counter_if bus();

   clock_time_counter #(.MAX_HOUR(23), .SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Any pulse or visible time change is an event that must match the next queued record.
   always @(negedge clk) begin
      if (mon_en) begin
         ev_t obs, e;
         obs = '{cyc, bus.hour_bcd, bus.min_bcd, bus.sec_bcd,
                 bus.tick_pulse, bus.min_carry, bus.day_carry, bus.load_err};
         if (obs.tp || obs.mc || obs.dc || obs.le ||
             {obs.h, obs.m, obs.s} != prev_time) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_event cyc=%0d time=%h:%h:%h tp=%b mc=%b dc=%b le=%b",
                        obs.cyc, obs.h, obs.m, obs.s, obs.tp, obs.mc, obs.dc, obs.le);
            end else begin
               e = exp_q.pop_front();
               if (obs != e) begin
                  failures++;
                  $display("FAIL event got cyc=%0d %h:%h:%h tp=%b mc=%b dc=%b le=%b expected cyc=%0d %h:%h:%h tp=%b mc=%b dc=%b le=%b",
                           obs.cyc, obs.h, obs.m, obs.s, obs.tp, obs.mc, obs.dc, obs.le,
                           e.cyc, e.h, e.m, e.s, e.tp, e.mc, e.dc, e.le);
               end
            end
         end
         prev_time = {obs.h, obs.m, obs.s};
      end
   end

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, want);
      end
   endtask

   // One tick_in high/low period; upd says whether the counter is expected to advance.
   task automatic send_tick(input bit upd, input logic [7:0] nh, input logic [7:0] nm,
                            input logic [7:0] ns, input bit mc, input bit dc);
      int n;
      @(posedge clk); #1;
      n = cyc;
      exp_q.push_back('{n + 3, cur_h, cur_m, cur_s, 1'b1, 1'b0, 1'b0, 1'b0});
      if (upd) begin
         exp_q.push_back('{n + 4, nh, nm, ns, 1'b0, mc, dc, 1'b0});
         cur_h = nh; cur_m = nm; cur_s = ns;
      end
      bus.tick_in = 1'b1;
      repeat (20) @(posedge clk);
      #1 bus.tick_in = 1'b0;
      repeat (20) @(posedge clk);
   endtask

   task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input bit ok);
      int n;
      @(posedge clk); #1;
      n = cyc;
      if (ok) begin
         exp_q.push_back('{n + 1, h, m, s, 1'b0, 1'b0, 1'b0, 1'b0});
         cur_h = h; cur_m = m; cur_s = s;
      end else begin
         exp_q.push_back('{n + 1, cur_h, cur_m, cur_s, 1'b0, 1'b0, 1'b0, 1'b1});
      end
      bus.load = 1'b1; bus.load_hour = h; bus.load_min = m; bus.load_sec = s;
      @(posedge clk); #1;
      bus.load = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      int n;
      bus.tick_in = 1'b1; bus.run = 1'b1; bus.load = 1'b0;
      bus.load_hour = 8'h00; bus.load_min = 8'h00; bus.load_sec = 8'h00;

      // Tick already high across reset release must not count.
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      check_val("reset_time", {8'h0, bus.hour_bcd, bus.min_bcd, bus.sec_bcd}, 32'h0);
      check_val("reset_pulses", {28'h0, bus.tick_pulse, bus.min_carry, bus.day_carry, bus.load_err}, 32'h0);
      repeat (20) @(posedge clk);
      #1 bus.tick_in = 1'b0;
      repeat (10) @(posedge clk);
      check_val("reset_hold_time", {8'h0, bus.hour_bcd, bus.min_bcd, bus.sec_bcd}, 32'h0);

      do_load(8'h12, 8'h34, 8'h58, 1'b1);
      send_tick(1'b1, 8'h12, 8'h34, 8'h59, 1'b0, 1'b0);
      send_tick(1'b1, 8'h12, 8'h35, 8'h00, 1'b1, 1'b0);

      do_load(8'h23, 8'h59, 8'h59, 1'b1);
      send_tick(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);

      do_load(8'h01, 8'h02, 8'h60, 1'b0);
      do_load(8'h24, 8'h00, 8'h00, 1'b0);
      do_load(8'h05, 8'h5A, 8'h00, 1'b0);
      do_load(8'h0A, 8'h00, 8'h00, 1'b0);

      bus.run = 1'b0;
      repeat (3) send_tick(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      bus.run = 1'b1;
      send_tick(1'b1, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);

      // Load lands in the same cycle the tick pulse is processed.
      @(posedge clk); #1;
      n = cyc;
      exp_q.push_back('{n + 3, cur_h, cur_m, cur_s, 1'b1, 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{n + 4, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
      cur_h = 8'h10; cur_m = 8'h00; cur_s = 8'h00;
      bus.tick_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.load = 1'b1; bus.load_hour = 8'h10; bus.load_min = 8'h00; bus.load_sec = 8'h00;
      @(posedge clk);
      #1 bus.load = 1'b0;
      repeat (16) @(posedge clk);
      #1 bus.tick_in = 1'b0;
      repeat (20) @(posedge clk);

      do_load(8'h09, 8'h59, 8'h59, 1'b1);
      send_tick(1'b1, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0);
      do_load(8'h19, 8'h09, 8'h29, 1'b1);
      send_tick(1'b1, 8'h19, 8'h09, 8'h30, 1'b0, 1'b0);

      repeat (30) @(posedge clk);
      check_val("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
